// File: rtl/block_mover.sv
// block_mover: responder for the Gremlin block-mover command interface.
// Moves 4-word bursts between the DRAM page window and the fabric port.
// A read goes from DRAM to the fabric; a write goes from the fabric to DRAM.
// Progress, completion and error flags are reported back to the requester.
module block_mover #(
  parameter int RD_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  RST_MVBLCK,
  input  logic        BLCK_ISSUE,
  input  logic [11:0] BLCK_START,
  input  logic [5:0]  BLCK_COUNT_REQ,
  input  logic [1:0]  BLCK_SECTION,
  output logic [5:0]  BLCK_COUNT_SENT,
  output logic        BLCK_WORKING,
  output logic        BLCK_IRQ,
  output logic        BLCK_ABRUPT_STOP,
  output logic        BLCK_FRDRAM_DEVERR,
  output logic [24:0] BLCK_ANCILL,
  output logic [11:0] MEM_ADDR,
  output logic        MEM_RE,
  output logic        MEM_WE,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ERR,
  input  logic [31:0] FAB_IN_DATA,
  input  logic        FAB_IN_VALID,
  input  logic        FAB_IN_LAST,
  input  logic        FAB_IN_IRQ,
  output logic        FAB_IN_READY,
  output logic [31:0] FAB_OUT_DATA,
  output logic        FAB_OUT_VALID,
  input  logic        FAB_OUT_READY
);
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {S_IDLE, S_RD_RUN, S_RD_DRAIN, S_WR_RUN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_working;
  logic [11:0]         r_start, r_last_addr, r_waddr;
  logic [7:0]          r_target, r_idx, r_done_words;
  logic [1:0]          r_section;
  logic                r_dir;
  logic [5:0]          r_count_sent;
  logic                r_irq, r_abrupt, r_deverr;
  logic [9:0]          r_cycles;
  logic [RD_LAT-1:0]   r_rd_vld;
  logic [2:0]          r_inflight, r_fcnt;
  logic [1:0]          r_wptr, r_rptr;
  logic [DATA_W-1:0]   r_fifo [4];
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;

  logic w_start_ok, w_run, w_abort, w_arrive, w_push, w_pop;
  logic w_issue, w_beat, w_word_done, w_early_last;

  // Saturating increment for the working-cycle counter.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign w_start_ok   = BLCK_ISSUE && (r_state == S_IDLE);
  assign w_run        = (r_state == S_RD_RUN) || (r_state == S_RD_DRAIN) || (r_state == S_WR_RUN);
  // 2'b11 is illegal and behaves exactly like 2'b00.
  assign w_abort      = w_run && (RST_MVBLCK[1] == RST_MVBLCK[0]);
  assign w_arrive     = r_rd_vld[RD_LAT-1];
  assign w_push       = w_arrive && !w_abort;
  assign w_pop        = FAB_OUT_VALID && FAB_OUT_READY;
  // A word popped this cycle frees its slot, so issue stays at 1 word/cycle.
  assign w_issue      = (r_state == S_RD_RUN) && !w_abort && !MEM_ERR && (r_idx != r_target) &&
                        ((4'(r_fcnt) + 4'(r_inflight) - 4'(w_pop)) < 4'd4);
  assign w_beat       = (r_state == S_WR_RUN) && FAB_IN_VALID;
  assign w_early_last = w_beat && FAB_IN_LAST && (r_idx + 8'd1 != r_target);
  assign w_word_done  = w_pop || r_we;

  assign BLCK_WORKING       = r_working;
  assign BLCK_COUNT_SENT    = r_count_sent;
  assign BLCK_IRQ           = r_irq;
  assign BLCK_ABRUPT_STOP   = r_abrupt;
  assign BLCK_FRDRAM_DEVERR = r_deverr;
  assign BLCK_ANCILL        = {r_dir, r_section, r_last_addr, r_cycles};
  assign MEM_RE             = w_issue;
  assign MEM_WE             = r_we;
  assign MEM_WDATA          = r_we ? r_wdata : '0;
  assign MEM_ADDR           = r_we ? r_waddr : (w_issue ? r_start + 12'(r_idx) : '0);
  assign FAB_IN_READY       = (r_state == S_WR_RUN);
  assign FAB_OUT_VALID      = (r_fcnt != 3'd0);
  assign FAB_OUT_DATA       = FAB_OUT_VALID ? r_fifo[r_rptr] : '0;

  // Next-state selection: abort beats device error beats normal progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (BLCK_ISSUE) begin
          if (BLCK_COUNT_REQ == 6'd0)     w_next = S_DONE;
          else if (RST_MVBLCK == 2'b10)   w_next = S_RD_RUN;
          else if (RST_MVBLCK == 2'b01)   w_next = S_WR_RUN;
          else                            w_next = S_DONE;
        end
      end
      S_RD_RUN: begin
        if (w_abort)                                      w_next = S_DONE;
        else if (MEM_ERR)                                 w_next = S_RD_DRAIN;
        else if (w_issue && (r_idx + 8'd1 == r_target))   w_next = S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        if (w_abort)                                      w_next = S_DONE;
        else if (r_fcnt == 3'd0 && r_inflight == 3'd0)    w_next = S_DONE;
      end
      S_WR_RUN: begin
        if (w_abort || MEM_ERR)                           w_next = S_DONE;
        else if (w_beat && ((r_idx + 8'd1 == r_target) || FAB_IN_LAST)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control and status registers: state, read pipeline/FIFO bookkeeping, counters, flags.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_working    <= 1'b0;
      r_we         <= 1'b0;
      r_rd_vld     <= '0;
      r_inflight   <= '0;
      r_fcnt       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_start      <= '0;
      r_target     <= '0;
      r_section    <= '0;
      r_dir        <= 1'b0;
      r_idx        <= '0;
      r_done_words <= '0;
      r_count_sent <= '0;
      r_irq        <= 1'b0;
      r_abrupt     <= 1'b0;
      r_deverr     <= 1'b0;
      r_last_addr  <= '0;
      r_cycles     <= '0;
    end else begin
      r_state   <= w_next;
      r_working <= (w_next != S_IDLE);
      r_we      <= w_beat;
      if (w_abort) begin
        r_rd_vld   <= '0;
        r_inflight <= '0;
        r_fcnt     <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        r_rd_vld   <= (r_rd_vld << 1) | RD_LAT'(w_issue);
        r_inflight <= r_inflight + 3'(w_issue) - 3'(w_arrive);
        r_fcnt     <= r_fcnt + 3'(w_push) - 3'(w_pop);
        if (w_push) r_wptr <= r_wptr + 2'd1;
        if (w_pop)  r_rptr <= r_rptr + 2'd1;
      end
      if (w_start_ok) begin
        r_start      <= BLCK_START;
        r_target     <= {BLCK_COUNT_REQ, 2'b00};
        r_section    <= BLCK_SECTION;
        r_dir        <= (RST_MVBLCK == 2'b10);
        r_idx        <= '0;
        r_done_words <= '0;
        r_count_sent <= '0;
        r_irq        <= 1'b0;
        r_abrupt     <= 1'b0;
        r_deverr     <= 1'b0;
        r_last_addr  <= BLCK_START;
        r_cycles     <= '0;
      end else begin
        if (w_issue || w_beat) r_idx <= r_idx + 8'd1;
        if (w_word_done) begin
          r_done_words <= r_done_words + 8'd1;
          if (r_done_words[1:0] == 2'b11) r_count_sent <= r_count_sent + 6'd1;
          r_last_addr <= r_we ? r_waddr : r_start + 12'(r_done_words);
        end
        if (w_beat && FAB_IN_IRQ)    r_irq    <= 1'b1;
        if (w_abort || w_early_last) r_abrupt <= 1'b1;
        if (r_working && MEM_ERR)    r_deverr <= 1'b1;
        if (r_working)               r_cycles <= sat_inc10(r_cycles);
      end
    end
  end

  // Datapath registers: read FIFO storage and the one-cycle write stage.
  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr] <= MEM_RDATA;
    if (w_beat) begin
      r_wdata <= FAB_IN_DATA;
      r_waddr <= r_start + 12'(r_idx);
    end
  end
endmodule

// File: doc/block_mover.md
# block_mover

Responder end of the Gremlin block-mover command interface. On each one-cycle `BLCK_ISSUE` pulse it moves `BLCK_COUNT_REQ` 4-word bursts between the DRAM page window and the hyperfabric switch port, in the direction selected by `RST_MVBLCK`. It reports progress and completion through `BLCK_WORKING` (the falling edge marks completion), `BLCK_COUNT_SENT`, `BLCK_IRQ` and the error/abort flags. It sits between the switch (`SWCH_ISEL`/`OSEL` path) and the MCU data port.

## Interface
- `RD_LAT`, default 2: fixed MEM_RE→MEM_RDATA latency in cycles (1..3).
- `CLK` in 1: clock.
- `RST` in 1: reset, synchronous, active-low.
- `RST_MVBLCK` in 2: 2'b10 = DRAM→fabric (read), 2'b01 = fabric→DRAM (write), 2'b00 = idle/abort, 2'b11 = illegal, treated as 2'b00.
- `BLCK_ISSUE` in 1: one-cycle start pulse.
- `BLCK_START` in 12: first word address.
- `BLCK_COUNT_REQ` in 6: burst count (4 words each); 0 is legal.
- `BLCK_SECTION` in 2: section tag, echoed in ANCILL.
- `BLCK_COUNT_SENT` out 6: completed full bursts.
- `BLCK_WORKING` out 1: high while a transfer is active.
- `BLCK_IRQ` out 1: sticky; `FAB_IN_IRQ` was seen during the transfer.
- `BLCK_ABRUPT_STOP` out 1: fabric ended the stream early.
- `BLCK_FRDRAM_DEVERR` out 1: `MEM_ERR` was seen during the transfer.
- `BLCK_ANCILL` out 25: {dir, section[1:0], last_addr[11:0], cycles[9:0]}.
- `MEM_ADDR` out 12, `MEM_RE` out 1, `MEM_WE` out 1, `MEM_WDATA` out 32, `MEM_RDATA` in 32, `MEM_ERR` in 1: DRAM data port.
- `FAB_IN_DATA` in 32, `FAB_IN_VALID` in 1, `FAB_IN_LAST` in 1, `FAB_IN_IRQ` in 1, `FAB_IN_READY` out 1: fabric source.
- `FAB_OUT_DATA` out 32, `FAB_OUT_VALID` out 1, `FAB_OUT_READY` in 1: fabric sink.

## Operation
- Reset: every output is 0; state is IDLE; the FIFO is empty.
- States:
  - IDLE: ISSUE with RST_MVBLCK=10 goes to RD_RUN; ISSUE with RST_MVBLCK=01 goes to WR_RUN.
  - ISSUE with RST_MVBLCK=00, or ISSUE with COUNT_REQ=0, goes to DONE.
  - ISSUE while not in IDLE is ignored.
- Start actions:
  - Latch start address, word target = COUNT_REQ×4 (8-bit), section and direction.
  - Clear COUNT_SENT, IRQ, ABRUPT_STOP, DEVERR and the cycle counter.
- RD_RUN:
  - Issue MEM_RE/MEM_ADDR while in-flight + FIFO occupancy < 4 and issued < target.
  - Read data enters a 4-deep FIFO that drives FAB_OUT.
  - When all words are issued, go to RD_DRAIN.
- RD_DRAIN: when the FIFO is empty and nothing is in flight, go to DONE.
- WR_RUN:
  - FAB_IN_READY = 1.
  - Each FAB_IN_VALID beat gives MEM_WE=1 with MEM_WDATA and MEM_ADDR on the next cycle.
  - When the last word is accepted, go to DONE.
  - FAB_IN_LAST on a beat before the target: accept that beat, set ABRUPT_STOP, go to DONE.
- DONE: drop WORKING, then go to IDLE.
- Addressing: MEM_ADDR = start + word index, mod 4096 (0xFFF wraps to 0x000).
- COUNT_SENT increments when a burst's 4th word completes:
  - read: FAB_OUT handshake;
  - write: MEM_WE.
  - A partial burst is not counted.
- IRQ: set on any accepted beat with FAB_IN_IRQ=1.
- DEVERR: set on MEM_ERR=1 while WORKING. It forces RD_DRAIN (read, with no further issues) or DONE (write).
- Abort: RST_MVBLCK=00 while WORKING:
  - next cycle: issues stop, the FIFO is flushed, ABRUPT_STOP=1, go to DONE;
  - in-flight read data is discarded;
  - COUNT_SENT keeps the bursts already completed.
- ANCILL:
  - cycles[9:0] counts WORKING cycles and saturates at 1023;
  - last_addr is the address of the final completed word (start if none).
- ANCILL, COUNT_SENT and the flags hold until the next ISSUE.

## Timing
- Start: ISSUE at cycle T gives WORKING=1 at T+1.
- First access: MEM_RE or FAB_IN_READY no earlier than T+1.
- Completion: WORKING falls 1 cycle after the DONE entry condition.
- WORKING is high for at least one cycle, including COUNT_REQ=0.
- COUNT_SENT, flags and ANCILL are final on the cycle WORKING is first 0.
- Read throughput: 1 word/cycle with READY held high; first FAB_OUT_VALID at T+1+RD_LAT+1.
- Backpressure: FAB_OUT_VALID and FAB_OUT_DATA hold while READY=0. Issue stalls at 4 outstanding. The FIFO never overflows.
- Write: 1 word/cycle; MEM_WE is 1 cycle after the accepted beat.
- Same-cycle events:
  - MEM_ERR together with the last beat: the beat completes, then DEVERR=1.
  - Abort together with ISSUE in IDLE: ISSUE wins and the transfer goes straight to DONE.

## Test plan
- Read of 2 bursts: ISSUE with RST_MVBLCK=10, START=0x010, COUNT=2, READY=1.
  - MEM_ADDR 0x010..0x017, 8 FAB_OUT beats in order.
  - COUNT_SENT=2; WORKING falls; ANCILL last_addr=0x017; flags 0.
- Write with wrap: RST_MVBLCK=01, START=0xFFE, COUNT=1, 4 beats.
  - MEM_WE at 0xFFE, 0xFFF, 0x000, 0x001.
  - COUNT_SENT=1.
- Early LAST: write, COUNT=3, LAST on beat 6.
  - ABRUPT_STOP=1, COUNT_SENT=1, 6 MEM_WE pulses.
- Read backpressure: COUNT=1, READY low for 10 cycles, then high.
  - At most 4 MEM_RE before the first handshake.
  - No data lost or duplicated; COUNT_SENT=1.
- COUNT_REQ=0:
  - WORKING high exactly 1 cycle; no MEM access; COUNT_SENT=0.
- Mid-transfer abort and IRQ: read, COUNT=4, RST_MVBLCK→00 after 5 beats.
  - ABRUPT_STOP=1, COUNT_SENT=1.
  - Then a write with FAB_IN_IRQ on beat 2 ends with IRQ=1.
